// File: rtl/ps2_kbc_sched_if.sv
// ps2_kbc_sched_if: CPU I/O port bus, scancode queue handshake and keyboard sideband lines.
interface ps2_kbc_sched_if;
   logic [11:0] port;
   logic [7:0]  din;
   logic [7:0]  dout;
   logic        cpu_iordin;
   logic        cpu_iordout;
   logic        cpu_iowrin;
   logic        cpu_iowrout;
   logic [7:0]  sc_data;
   logic        sc_valid;
   logic        sc_ready;
   logic        irq1;
   logic        a20;
   modport master (
      output port, din, cpu_iordin, cpu_iowrin, sc_data, sc_valid,
      input  dout, cpu_iordout, cpu_iowrout, sc_ready, irq1, a20
   );
   modport slave (
      input  port, din, cpu_iordin, cpu_iowrin, sc_data, sc_valid,
      output dout, cpu_iordout, cpu_iowrout, sc_ready, irq1, a20
   );
endinterface

// File: rtl/ps2_kbc_sched.sv
// ps2_kbc_sched: i8042-style controller front end; arbitrates the port 60h output buffer
// between command replies and queued scancodes, holds the command byte and A20 gate.
module ps2_kbc_sched #(
   parameter logic [11:0] PORT_DATA     = 12'h060,
   parameter logic [11:0] PORT_CMD      = 12'h064,
   parameter logic [7:0]  CMD_BYTE_INIT = 8'h45
) (
   input  logic           clk,
   input  logic           reset,
   ps2_kbc_sched_if.slave bus
);
   typedef enum logic [1:0] {IDLE, WAIT_CMDB, WAIT_OUTP} state_t;
   state_t     r_state, w_state_nx;
   logic [7:0] r_dout, r_obuf, r_reply, r_cmd, w_rep_val;
   logic       r_iordout, r_iowrout, r_obf, r_reply_pend, r_sc_ready, r_irq1, r_a20, r_a2;
   logic       w_rd60, w_rd64, w_wr60, w_wr64;
   logic       w_rep, w_cmdb, w_outp, w_kbd_dis, w_kbd_en, w_ld_rep, w_ld_sc;

   assign w_rd60 = bus.cpu_iordin != r_iordout && bus.port == PORT_DATA;
   assign w_rd64 = bus.cpu_iordin != r_iordout && bus.port == PORT_CMD;
   assign w_wr60 = bus.cpu_iowrin != r_iowrout && bus.port == PORT_DATA;
   assign w_wr64 = bus.cpu_iowrin != r_iowrout && bus.port == PORT_CMD;
   // a pending reply always wins the empty buffer over a waiting scancode
   assign w_ld_rep = !r_obf && r_reply_pend;
   assign w_ld_sc  = !r_obf && !r_reply_pend && bus.sc_valid && !r_sc_ready && !r_cmd[4];

   always_ff @(posedge clk)
      if (reset) r_state <= IDLE;
      else r_state <= w_state_nx;

   always_comb begin
      w_state_nx = r_state;
      if (w_wr64)
         w_state_nx = bus.din == 8'h60 ? WAIT_CMDB : bus.din == 8'hD1 ? WAIT_OUTP : IDLE;
      else if (w_wr60)
         w_state_nx = IDLE;
   end

   always_comb begin
      w_cmdb    = w_wr60 && r_state == WAIT_CMDB;
      w_outp    = w_wr60 && r_state == WAIT_OUTP;
      w_kbd_dis = w_wr64 && bus.din == 8'hAD;
      w_kbd_en  = w_wr64 && bus.din == 8'hAE;
      w_rep     = (w_wr60 && r_state == IDLE) ||
                  (w_wr64 && (bus.din == 8'h20 || bus.din == 8'hAA || bus.din == 8'hAB));
      w_rep_val = w_wr60 ? (bus.din == 8'hEE ? 8'hEE : 8'hFA) :
                  bus.din == 8'h20 ? r_cmd : bus.din == 8'hAA ? 8'h55 : 8'h00;
   end

   always_ff @(posedge clk) begin
      r_iordout <= bus.cpu_iordin;
      r_iowrout <= bus.cpu_iowrin;
      if (reset) begin
         r_dout       <= 8'h00;
         r_obuf       <= 8'h00;
         r_obf        <= 1'b0;
         r_reply      <= 8'h00;
         r_reply_pend <= 1'b0;
         r_cmd        <= CMD_BYTE_INIT;
         r_sc_ready   <= 1'b0;
         r_irq1       <= 1'b0;
         r_a20        <= 1'b0;
         r_a2         <= 1'b0;
      end else begin
         r_sc_ready <= w_ld_sc;
         r_irq1     <= r_obf & r_cmd[0];
         if (w_rd60) begin
            r_dout <= r_obuf;
            r_obf  <= 1'b0;
         end
         if (w_rd64) r_dout <= {4'b0, r_a2, r_cmd[2], 1'b0, r_obf};
         if (w_ld_rep || w_ld_sc) begin
            r_obuf <= w_ld_rep ? r_reply : bus.sc_data;
            r_obf  <= 1'b1;
         end
         if (w_ld_rep) r_reply_pend <= 1'b0;
         // a fresh reply overwrites the slot even if the old one was just consumed
         if (w_rep) begin
            r_reply      <= w_rep_val;
            r_reply_pend <= 1'b1;
         end
         if (w_wr60 || w_wr64) r_a2 <= w_wr64;
         if (w_cmdb) r_cmd <= bus.din;
         if (w_kbd_dis) r_cmd[4] <= 1'b1;
         if (w_kbd_en) r_cmd[4] <= 1'b0;
         if (w_outp) r_a20 <= bus.din[1];
      end
   end

   assign bus.dout        = r_dout;
   assign bus.cpu_iordout = r_iordout;
   assign bus.cpu_iowrout = r_iowrout;
   assign bus.sc_ready    = r_sc_ready;
   assign bus.irq1        = r_irq1;
   assign bus.a20         = r_a20;
endmodule

// File: doc/ps2_kbc_sched.md
Name: ps2_kbc_sched

Overview:
- i8042-style keyboard-controller front end for the 286 core; sits between the CPU I/O bus (ports 60h/64h) and the keyboard scancode queue fed by the RISC-V side.
- Arbitrates the single 8-bit output buffer (port 60h) between two requesters: controller/keyboard command replies and queued scancodes.
- Executes the minimal controller command set, holds the command byte and A20 gate, and generates IRQ1.

Parameters:
- PORT_DATA, 12'h060, I/O address of the data port.
- PORT_CMD, 12'h064, I/O address of the status/command port.
- CMD_BYTE_INIT, 8'h45, command byte after reset (bit0 IRQ enable, bit4 keyboard disable).

Ports:
- clk  in  1  system clock; all logic on posedge.
- reset  in  1  synchronous, active-high reset.
- port  in  12  CPU I/O address.
- din  in  8  CPU write data.
- dout  out  8  CPU read data, registered.
- cpu_iordin  in  1  read request toggle.
- cpu_iordout  out  1  read acknowledge toggle.
- cpu_iowrin  in  1  write request toggle.
- cpu_iowrout  out  1  write acknowledge toggle.
- sc_data  in  8  scancode from the keyboard queue.
- sc_valid  in  1  scancode available; held until accepted.
- sc_ready  out  1  one-cycle accept pulse.
- irq1  out  1  keyboard interrupt level.
- a20  out  1  A20 gate.

Behaviour:
- Reset values: dout=0, cpu_iordout=cpu_iordin, cpu_iowrout=cpu_iowrin, sc_ready=0, irq1=0, a20=0. Internal reset values: obuf=0, obf=0, reply_pend=0, cmd_byte=CMD_BYTE_INIT, state=IDLE, a2=0.
  - Reset mid-operation drops any pending reply and any half-done two-byte command.
- CPU handshake:
  - A read is pending while cpu_iordin != cpu_iordout; a write is pending while cpu_iowrin != cpu_iowrout.
  - The block services a pending request on the next posedge and copies in->out in that same cycle (1-cycle latency).
  - dout is updated in the same cycle as the acknowledge.
  - An address other than 60h/64h is acknowledged but has no effect on state. dout is left unchanged for reads of other addresses.
- Read 60h: dout=obuf, obf cleared. Read 64h: dout={4'b0, a2, cmd_byte[2], 1'b0 (IBF), obf}; no side effects.
- Write 64h (a2<=1): the command is decoded as follows.
  - 20h: reply = cmd_byte.
  - 60h: state -> WAIT_CMDB.
  - D1h: state -> WAIT_OUTP.
  - AAh: reply = 55h.
  - ABh: reply = 00h.
  - ADh: cmd_byte[4]<=1. AEh: cmd_byte[4]<=0.
  - Any other command is ignored.
  - A command written in a WAIT state replaces the wait and returns to IDLE before decode.
- Write 60h (a2<=0):
  - WAIT_CMDB: cmd_byte<=din, then IDLE.
  - WAIT_OUTP: a20<=din[1], then IDLE.
  - IDLE: keyboard command. EEh replies EEh; any other value replies FAh.
- Reply slot: single entry, with reply_pend set when a reply is generated. A new reply overwrites an unconsumed one.
- Output-buffer arbiter, evaluated each cycle while obf=0:
  - Priority 1: if reply_pend, obuf<=reply, obf<=1, reply_pend<=0.
  - Priority 2: if sc_valid && !sc_ready && cmd_byte[4]==0, obuf<=sc_data, obf<=1, sc_ready<=1 for one cycle.
  - The load is never in the same cycle that a 60h read clears obf; the earliest reload is the following cycle.
- sc_ready is never high two consecutive cycles. A scancode is held, not dropped, while disabled or while obf=1.
- irq1 <= obf & cmd_byte[0], registered, so it falls one cycle after the 60h read that clears obf.
- Simultaneous pending read and write are both serviced in the same cycle; the read observes pre-write state.

Test Plan:
- Reset, then read 64h -> dout=04h, irq1=0, a20=0. Read 60h -> dout=00h.
- sc_valid with sc_data=1Ch -> single sc_ready pulse; status reads 05h; irq1=1. Read 60h -> 1Ch; irq1=0 next cycle.
  - Back-to-back scancodes 1Ch then 9Ch -> the second loads only after the first is read; neither is lost.
- Write 64h=AAh while scancode 2Ah is waiting -> read 60h gives 55h first, then 2Ah. Read 64h after the AAh write -> bit3=1.
- Write 64h=60h, then 60h=44h -> read via 20h returns 44h. Scancode 1Eh with sc_valid high -> loaded, but irq1 stays 0 (bit0 clear).
- Write 64h=ADh with sc_valid high -> sc_ready stays 0 for 100 cycles. Write AEh -> accepted.
  - Write 64h=D1h, then 60h=02h -> a20=1. Write 60h=EDh -> reply FAh.
- Assert reset while in WAIT_CMDB with reply_pend set, then write 60h=00h -> reply FAh; cmd_byte=45h.
